// File: rtl/crc_pkg.sv
// Shared types and Gen2 CRC constants for the serial CRC check/generate engine.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EMIT,
        ST_DONE
    } crc_state_e;

    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

    localparam logic [4:0]  CRC5_POLY     = 5'h09;
    localparam logic [4:0]  CRC5_PRESET   = 5'h09;
    localparam logic [4:0]  CRC5_RESIDUE  = 5'h00;

endpackage

// File: rtl/crc_lfsr_step.sv
// One MSB-first LFSR step: next CRC register from current CRC and one data bit.
module crc_lfsr_step #(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(16'h1021)
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc_out
);

    logic fb;

    always_comb begin
        fb      = bit_in ^ crc_in[CRC_W-1];
        crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

endmodule

// File: rtl/crc_check_engine.sv
// Serial CRC engine: absorbs a framed bit stream, then either checks the
// remainder against a residue or shifts the (optionally inverted) CRC out.
module crc_check_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC16_POLY),
    parameter logic [CRC_W-1:0] PRESET  = {CRC_W{1'b1}},
    parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(CRC16_RESIDUE),
    parameter bit               INV_OUT = 1'b1,
    parameter int               CNT_W   = 9
) (
    input  logic             crcinclk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             bitvalid,
    input  logic             crcbitin,
    input  logic             endframe,
    output logic [CRC_W-1:0] crc,
    output logic [CNT_W-1:0] bitcount,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crcbitout,
    output logic             crcbitvalid
);

    localparam int               EW      = $clog2(CRC_W + 1);
    localparam logic [EW-1:0]    EMIT_N  = EW'(CRC_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    crc_state_e       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] bitcount_q, bitcount_d;
    logic [EW-1:0]    emit_cnt_q, emit_cnt_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             crc_ok_q, crc_ok_d;
    logic             crcbitout_q, crcbitout_d;
    logic             crcbitvalid_q, crcbitvalid_d;

    logic [CRC_W-1:0] crc_step;
    logic [CRC_W-1:0] crc_shift;
    logic [CNT_W-1:0] cnt_inc;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc_in  (crc_q),
        .bit_in  (crcbitin),
        .crc_out (crc_step)
    );

    always_comb begin
        crc_shift = bitvalid ? crc_step : crc_q;
        cnt_inc   = (bitcount_q == CNT_MAX) ? bitcount_q
                                            : bitcount_q + 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        bitcount_d    = bitcount_q;
        emit_cnt_d    = emit_cnt_q;
        mode_d        = mode_q;
        done_d        = done_q;
        crc_ok_d      = crc_ok_q;
        crcbitout_d   = 1'b0;
        crcbitvalid_d = 1'b0;

        if (start) begin
            state_d    = ST_SHIFT;
            crc_d      = PRESET;
            bitcount_d = '0;
            emit_cnt_d = '0;
            mode_d     = mode;
            done_d     = 1'b0;
            crc_ok_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_SHIFT: begin
                    if (bitvalid) begin
                        crc_d      = crc_step;
                        bitcount_d = cnt_inc;
                    end
                    // The bit qualified alongside endframe is the last data bit.
                    if (endframe) begin
                        if (!mode_q) begin
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                            crc_ok_d = (crc_shift == RESIDUE);
                        end else begin
                            state_d       = ST_EMIT;
                            crcbitvalid_d = 1'b1;
                            crcbitout_d   = crc_shift[CRC_W-1] ^ INV_OUT;
                            crc_d         = {crc_shift[CRC_W-2:0], 1'b1};
                            emit_cnt_d    = EW'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (emit_cnt_q == EMIT_N) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        crc_ok_d = 1'b0;
                    end else begin
                        crcbitvalid_d = 1'b1;
                        crcbitout_d   = crc_q[CRC_W-1] ^ INV_OUT;
                        crc_d         = {crc_q[CRC_W-2:0], 1'b1};
                        emit_cnt_d    = emit_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == ST_SHIFT) || (state_d == ST_EMIT);
    end

    always_ff @(posedge crcinclk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            crc_q         <= PRESET;
            bitcount_q    <= '0;
            emit_cnt_q    <= '0;
            mode_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            crc_ok_q      <= 1'b0;
            crcbitout_q   <= 1'b0;
            crcbitvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            bitcount_q    <= bitcount_d;
            emit_cnt_q    <= emit_cnt_d;
            mode_q        <= mode_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            crc_ok_q      <= crc_ok_d;
            crcbitout_q   <= crcbitout_d;
            crcbitvalid_q <= crcbitvalid_d;
        end
    end

    assign crc         = crc_q;
    assign bitcount    = bitcount_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign crc_ok      = crc_ok_q;
    assign crcbitout   = crcbitout_q;
    assign crcbitvalid = crcbitvalid_q;

endmodule

// File: tb/tb_crc_check_engine.sv
// Bench for crc_check_engine: a CRC16 and a CRC5/CNT_W=4 instance share one
// stimulus stream and are each compared every cycle against a frame-level model.
module tb_crc_check_engine;
    import crc_pkg::*;

    logic clk;
    logic reset, start, mode, bitvalid, crcbitin, endframe;

    logic [15:0] crc0;
    logic [8:0]  cnt0;
    logic        busy0, done0, ok0, bo0, bv0;
    logic [4:0]  crc1;
    logic [3:0]  cnt1;
    logic        busy1, done1, ok1, bo1, bv1;

    crc_check_engine u0 (
        .crcinclk (clk), .reset (reset), .start (start), .mode (mode),
        .bitvalid (bitvalid), .crcbitin (crcbitin), .endframe (endframe),
        .crc (crc0), .bitcount (cnt0), .busy (busy0), .done (done0),
        .crc_ok (ok0), .crcbitout (bo0), .crcbitvalid (bv0)
    );

    crc_check_engine #(
        .CRC_W (5), .POLY (CRC5_POLY), .PRESET (CRC5_PRESET),
        .RESIDUE (CRC5_RESIDUE), .INV_OUT (1'b0), .CNT_W (4)
    ) u1 (
        .crcinclk (clk), .reset (reset), .start (start), .mode (mode),
        .bitvalid (bitvalid), .crcbitin (crcbitin), .endframe (endframe),
        .crc (crc1), .bitcount (cnt1), .busy (busy1), .done (done1),
        .crc_ok (ok1), .crcbitout (bo1), .crcbitvalid (bv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Per-instance configuration.
    int          P_W    [2] = '{16, 5};
    logic [15:0] P_POLY [2] = '{16'h1021, 16'h0009};
    logic [15:0] P_PRE  [2] = '{16'hFFFF, 16'h0009};
    logic [15:0] P_RES  [2] = '{16'h1D0F, 16'h0000};
    bit          P_INV  [2] = '{1'b1, 1'b0};
    int          P_CMAX [2] = '{511, 15};

    // Model state: phase 0 idle, 1 shift, 2 emit, 3 done.
    int          m_phase [2];
    logic [15:0] m_crc   [2];
    int          m_cnt   [2];
    bit          m_mode  [2];
    bit          m_done  [2];
    bit          m_ok    [2];
    bit          m_bv    [2];
    bit          m_bo    [2];
    logic [15:0] m_word  [2];
    int          m_left  [2];

    logic msg[$];
    logic [15:0] cap0;
    logic [4:0]  cap1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] wmask(input int i);
        return 16'((32'd1 << P_W[i]) - 1);
    endfunction

    function automatic logic [15:0] stp(input logic [15:0] c, input logic b,
                                        input int i);
        logic fb;
        fb = b ^ c[P_W[i]-1];
        return ((c << 1) & wmask(i)) ^ (fb ? P_POLY[i] : 16'h0);
    endfunction

    task automatic model_reset(input int i);
        m_phase[i] = 0; m_crc[i] = P_PRE[i]; m_cnt[i] = 0; m_mode[i] = 0;
        m_done[i] = 0; m_ok[i] = 0; m_bv[i] = 0; m_bo[i] = 0;
        m_word[i] = 0; m_left[i] = 0;
    endtask

    task automatic emit_bit(input int i);
        m_bv[i]   = 1'b1;
        m_bo[i]   = m_word[i][P_W[i]-1];
        m_word[i] = (m_word[i] << 1) & wmask(i);
        m_crc[i]  = ((m_crc[i] << 1) | 16'h1) & wmask(i);
        m_left[i] = m_left[i] - 1;
    endtask

    task automatic model_edge(input int i, input bit rs, input bit st,
                              input bit md, input bit bv, input bit bi,
                              input bit ef);
        if (rs) begin
            model_reset(i);
        end else if (st) begin
            m_crc[i] = P_PRE[i]; m_cnt[i] = 0; m_done[i] = 0; m_ok[i] = 0;
            m_bv[i] = 0; m_bo[i] = 0; m_mode[i] = md; m_phase[i] = 1;
        end else begin
            m_bv[i] = 0; m_bo[i] = 0;
            if (m_phase[i] == 1) begin
                if (bv) begin
                    m_crc[i] = stp(m_crc[i], bi, i);
                    if (m_cnt[i] < P_CMAX[i]) m_cnt[i]++;
                end
                if (ef && !m_mode[i]) begin
                    m_phase[i] = 3; m_done[i] = 1;
                    m_ok[i] = (m_crc[i] == P_RES[i]);
                end else if (ef) begin
                    m_phase[i] = 2;
                    m_word[i] = m_crc[i] ^ (P_INV[i] ? wmask(i) : 16'h0);
                    m_left[i] = P_W[i];
                    emit_bit(i);
                end
            end else if (m_phase[i] == 2) begin
                if (m_left[i] == 0) begin
                    m_phase[i] = 3; m_done[i] = 1; m_ok[i] = 0;
                end else begin
                    emit_bit(i);
                end
            end
        end
    endtask

    task automatic cycle(input bit rs, input bit st, input bit md,
                         input bit bv, input bit bi, input bit ef);
        reset = rs; start = st; mode = md;
        bitvalid = bv; crcbitin = bi; endframe = ef;
        if (rs) begin
            model_reset(0);
            model_reset(1);
        end
        @(posedge clk);
        model_edge(0, rs, st, md, bv, bi, ef);
        model_edge(1, rs, st, md, bv, bi, ef);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) msg.push_back(b[k]);
    endtask

    task automatic load_digits();
        msg.delete();
        for (int c = 8'h31; c <= 8'h39; c++) add_byte(8'(c));
    endtask

    task automatic send_frame(input bit md, input bit gaps);
        cycle(0, 1, md, 0, 0, 0);
        if (msg.size() == 0) cycle(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < msg.size(); k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) cycle(0, 0, 0, 0, 1'($urandom), 0);
            cycle(0, 0, 0, 1, msg[k], k == msg.size() - 1);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("crc0", 32'(crc0), 32'(m_crc[0]));
            chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
            chk("busy0", 32'(busy0), 32'(m_phase[0] == 1 || m_phase[0] == 2));
            chk("done0", 32'(done0), 32'(m_done[0]));
            chk("ok0", 32'(ok0), 32'(m_ok[0]));
            chk("bv0", 32'(bv0), 32'(m_bv[0]));
            if (m_bv[0]) chk("bo0", 32'(bo0), 32'(m_bo[0]));
            chk("crc1", 32'(crc1), 32'(m_crc[1][4:0]));
            chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
            chk("busy1", 32'(busy1), 32'(m_phase[1] == 1 || m_phase[1] == 2));
            chk("done1", 32'(done1), 32'(m_done[1]));
            chk("ok1", 32'(ok1), 32'(m_ok[1]));
            chk("bv1", 32'(bv1), 32'(m_bv[1]));
            if (m_bv[1]) chk("bo1", 32'(bo1), 32'(m_bo[1]));
        end
    end

    always @(negedge clk) begin
        if (bv0) cap0 <= {cap0[14:0], bo0};
        if (bv1) cap1 <= {cap1[3:0], bo1};
    end

    initial begin
        logic [15:0] c;
        int idx;
        bit md;
        int n;

        reset = 1; start = 0; mode = 0; bitvalid = 0; crcbitin = 0; endframe = 0;
        model_reset(0);
        model_reset(1);
        chk_en = 1'b1;
        cycle(1, 0, 0, 0, 0, 0);
        chk("rst_crc0", 32'(crc0), 32'hFFFF);
        chk("rst_crc1", 32'(crc1), 32'h09);
        chk("rst_busy", 32'(busy0), 32'h0);
        cycle(0, 0, 0, 1, 1, 1);
        idle(3);

        // Generate over "123456789".
        load_digits();
        cap0 = '0;
        send_frame(1, 0);
        idle(20);
        chk("gen_d64e", 32'(cap0), 32'hD64E);
        chk("gen_done", 32'(done0), 32'h1);
        chk("gen_cnt", 32'(cnt0), 32'd72);

        // Check: message plus its CRC leaves the residue.
        for (int k = 15; k >= 0; k--) begin
            c = 16'hD64E;
            msg.push_back(c[k]);
        end
        send_frame(0, 1);
        idle(2);
        chk("chk_res", 32'(crc0), 32'h1D0F);
        chk("chk_ok", 32'(ok0), 32'h1);
        chk("chk_cnt", 32'(cnt0), 32'd88);
        chk("chk_sat4", 32'(cnt1), 32'd15);
        idx = $urandom_range(0, 87);
        msg[idx] = ~msg[idx];
        send_frame(0, 1);
        idle(2);
        chk("chk_flip", 32'(ok0), 32'h0);

        // Empty generate frame.
        msg.delete();
        cap0 = 16'h1234;
        cap1 = '0;
        send_frame(1, 0);
        idle(20);
        chk("empty5", 32'(cap1), 32'b01001);
        chk("empty16", 32'(cap0), 32'h0000);
        chk("empty_cnt1", 32'(cnt1), 32'd0);

        // Start wins over coincident bitvalid/endframe.
        cycle(0, 1, 0, 1, 1, 1);
        chk("st_busy", 32'(busy0), 32'h1);
        chk("st_cnt", 32'(cnt0), 32'd0);
        chk("st_crc", 32'(crc0), 32'hFFFF);
        chk("st_done", 32'(done0), 32'h0);
        idle(2);

        // Reset during emission after 7 bits.
        load_digits();
        send_frame(1, 0);
        idle(6);
        chk("mid_emit", 32'(bv0), 32'h1);
        cycle(1, 0, 0, 1, 1, 1);
        chk("abort_bv", 32'(bv0), 32'h0);
        chk("abort_busy", 32'(busy0), 32'h0);
        chk("abort_crc", 32'(crc0), 32'hFFFF);
        cycle(0, 0, 0, 1, 1, 1);
        idle(2);
        cap0 = '0;
        send_frame(1, 1);
        idle(20);
        chk("rerun_d64e", 32'(cap0), 32'hD64E);

        // Saturation on the narrow counter.
        msg.delete();
        repeat (20) msg.push_back(1'($urandom));
        send_frame(0, 1);
        idle(2);
        chk("sat_cnt1", 32'(cnt1), 32'd15);
        chk("sat_cnt0", 32'(cnt0), 32'd20);

        // Random good frames: check mode must accept data plus inverted CRC.
        for (int f = 0; f < 8; f++) begin
            msg.delete();
            n = $urandom_range(0, 40);
            repeat (n) msg.push_back(1'($urandom));
            md = 1'($urandom);
            if (!md) begin
                c = 16'hFFFF;
                foreach (msg[k]) c = stp(c, msg[k], 0);
                c = ~c;
                for (int k = 15; k >= 0; k--) msg.push_back(c[k]);
            end
            send_frame(md, 1);
            idle(20);
            if (!md) chk("rand_ok", 32'(ok0), 32'h1);
        end

        // Unstructured random traffic, including resets and restarts.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 11) == 0));
        end
        cycle(0, 0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
